// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer for the 5-stage core: stage enables, valid bits,
// PC control and performance counters derived from stall/flush requests.
module pipe_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_flush,
  input  logic                 ctrl_flush,
  input  logic                 dmem_busy,
  output logic                 pc_en,
  output logic                 pc_sel_redirect,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_valid,
  output logic                 idex_valid,
  output logic                 exmem_valid,
  output logic                 memwb_valid,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic cf, df;
  logic ifid_nxt, idex_nxt, exmem_nxt, memwb_nxt;
  logic stall_inc, flush_inc, retire_inc;

  // Requests only count when the instruction raising them is real.
  assign cf = ctrl_flush & idex_valid;
  assign df = data_flush & ifid_valid & ~cf;

  assign retire_inc = memwb_valid & memwb_en;

  // Next-state, enables and next valid bits; priority busy > cf > df > advance.
  always_comb begin
    state_nxt       = state;
    pc_en           = 1'b0;
    pc_sel_redirect = 1'b0;
    ifid_en         = 1'b0;
    idex_en         = 1'b0;
    exmem_en        = 1'b0;
    memwb_en        = 1'b0;
    ifid_nxt        = ifid_valid;
    idex_nxt        = idex_valid;
    exmem_nxt       = exmem_valid;
    memwb_nxt       = memwb_valid;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (!rst) begin
      case (state)
        S_RESET: begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          idex_en   = 1'b1;
          exmem_en  = 1'b1;
          memwb_en  = 1'b1;
          ifid_nxt  = 1'b0;
          idex_nxt  = ifid_valid;
          exmem_nxt = idex_valid;
          memwb_nxt = exmem_valid;
          state_nxt = S_RUN;
        end
        S_RUN, S_REDIR: begin
          if (dmem_busy) begin
            stall_inc = 1'b1;
          end else if (cf) begin
            pc_en           = 1'b1;
            pc_sel_redirect = 1'b1;
            ifid_en         = 1'b1;
            idex_en         = 1'b1;
            exmem_en        = 1'b1;
            memwb_en        = 1'b1;
            ifid_nxt        = 1'b0;
            idex_nxt        = 1'b0;
            exmem_nxt       = 1'b1;
            memwb_nxt       = exmem_valid;
            flush_inc       = 1'b1;
            state_nxt       = S_REDIR;
          end else if (df) begin
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            idex_nxt  = 1'b0;
            exmem_nxt = idex_valid;
            memwb_nxt = exmem_valid;
            stall_inc = 1'b1;
            state_nxt = S_RUN;
          end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            // Fetch word in the cycle after a redirect is still old-path.
            ifid_nxt  = (state == S_RUN);
            idex_nxt  = ifid_valid;
            exmem_nxt = idex_valid;
            memwb_nxt = exmem_valid;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_RESET;
      endcase
    end
  end

  // State, valid bits and wrapping counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      ifid_valid  <= 1'b0;
      idex_valid  <= 1'b0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
      retire_cnt  <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      ifid_valid  <= ifid_nxt;
      idex_valid  <= idex_nxt;
      exmem_valid <= exmem_nxt;
      memwb_valid <= memwb_nxt;
      if (retire_inc) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      if (stall_inc)  stall_cnt  <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc)  flush_cnt  <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vectors with combinational checks
// before the edge and registered results scoreboarded across the edge.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, data_flush, ctrl_flush, dmem_busy;
  logic          pc_en, pc_sel_redirect;
  logic          ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_valid, idex_valid, exmem_valid, memwb_valid;
  logic [CW-1:0] retire_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string name;
    logic  rst, df, cf, busy;
    int    pc_en, sel, en, vld, ret, stl, fls;  // -1 means not checked
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  pipe_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .data_flush(data_flush), .ctrl_flush(ctrl_flush), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_valid(ifid_valid), .idex_valid(idex_valid),
    .exmem_valid(exmem_valid), .memwb_valid(memwb_valid),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic df,
                              input logic cf, input logic busy, input int pe,
                              input int sel, input int en, input int vld,
                              input int ret, input int stl, input int fls);
    vec_t v;
    v.name = name; v.rst = r; v.df = df; v.cf = cf; v.busy = busy;
    v.pc_en = pe; v.sel = sel; v.en = en; v.vld = vld;
    v.ret = ret; v.stl = stl; v.fls = fls;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
    end
  endtask

  // Drive one cycle: combinational outputs checked mid-cycle, registered
  // results pushed to the scoreboard and compared after the rising edge.
  task automatic apply(input vec_t v);
    vec_t e;
    int   en_act, vld_act;
    @(negedge clk);
    rst = v.rst; data_flush = v.df; ctrl_flush = v.cf; dmem_busy = v.busy;
    #1;
    en_act = int'({ifid_en, idex_en, exmem_en, memwb_en});
    chk({v.name, ".pc_en"}, int'(pc_en), v.pc_en);
    chk({v.name, ".pc_sel_redirect"}, int'(pc_sel_redirect), v.sel);
    chk({v.name, ".enables"}, en_act, v.en);
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", v.name);
    end else begin
      e = sb.pop_front();
      vld_act = int'({ifid_valid, idex_valid, exmem_valid, memwb_valid});
      chk({e.name, ".valids"}, vld_act, e.vld);
      chk({e.name, ".retire_cnt"}, int'(retire_cnt), e.ret);
      chk({e.name, ".stall_cnt"}, int'(stall_cnt), e.stl);
      chk({e.name, ".flush_cnt"}, int'(flush_cnt), e.fls);
    end
  endtask

  initial begin
    rst = 1'b1; data_flush = 1'b0; ctrl_flush = 1'b0; dmem_busy = 1'b0;

    //                 name     rst df cf bsy pc sel en       vld      ret stl fls
    tbl.push_back(mk("rst0",    1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("rst1",    1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("fill1",   0, 0, 0, 0, 1, 0, -1,      4'b0000, 0, 0, 0));
    tbl.push_back(mk("fill2",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1000, 0, 0, 0));
    tbl.push_back(mk("fill3",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1100, 0, 0, 0));
    tbl.push_back(mk("fill4",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1110, 0, 0, 0));
    tbl.push_back(mk("fill5",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 0, 0, 0));
    tbl.push_back(mk("fill6",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 1, 0, 0));
    tbl.push_back(mk("run7",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 2, 0, 0));
    tbl.push_back(mk("lu",      0, 1, 0, 0, 0, 0, 4'b0111, 4'b1011, 3, 1, 0));
    tbl.push_back(mk("lu+1",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1101, 4, 1, 0));
    tbl.push_back(mk("lu+2",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1110, 5, 1, 0));
    tbl.push_back(mk("lu+3",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 5, 1, 0));
    tbl.push_back(mk("lu+4",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 6, 1, 0));
    tbl.push_back(mk("br",      0, 0, 1, 0, 1, 1, 4'b1111, 4'b0011, 7, 1, 1));
    tbl.push_back(mk("br+1",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b0001, 8, 1, 1));
    tbl.push_back(mk("br+2",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1000, 9, 1, 1));
    tbl.push_back(mk("br+3",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1100, 9, 1, 1));
    tbl.push_back(mk("br+4",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1110, 9, 1, 1));
    tbl.push_back(mk("br+5",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 9, 1, 1));
    tbl.push_back(mk("br+6",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 10, 1, 1));
    tbl.push_back(mk("frz1",    0, 0, 1, 1, 0, 0, 4'b0000, 4'b1111, 10, 2, 1));
    tbl.push_back(mk("frz2",    0, 0, 1, 1, 0, 0, 4'b0000, 4'b1111, 10, 3, 1));
    tbl.push_back(mk("frz3",    0, 0, 1, 1, 0, 0, 4'b0000, 4'b1111, 10, 4, 1));
    tbl.push_back(mk("frz_rel", 0, 0, 1, 0, 1, 1, 4'b1111, 4'b0011, 11, 4, 2));
    tbl.push_back(mk("rel+1",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b0001, 12, 4, 2));
    tbl.push_back(mk("rel+2",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1000, 13, 4, 2));
    tbl.push_back(mk("rel+3",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1100, 13, 4, 2));
    tbl.push_back(mk("rel+4",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1110, 13, 4, 2));
    tbl.push_back(mk("rel+5",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 13, 4, 2));
    tbl.push_back(mk("rel+6",   0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111, 14, 4, 2));
    tbl.push_back(mk("sim",     0, 1, 1, 0, 1, 1, 4'b1111, 4'b0011, 15, 4, 3));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // In S_REDIR both requests are unqualified (ID/EX squashed): ignored,
    // and the 16th retirement wraps the 4-bit counter.
    apply(mk("redir_unq", 0, 1, 1, 0, 1, 0, 4'b1111, 4'b0001, 0, 4, 3));
    apply(mk("wrap17",    0, 0, 0, 0, 1, 0, 4'b1111, 4'b1000, 1, 4, 3));
    // Reset asserted in the middle of a load-use stall.
    apply(mk("lu2",       0, 1, 0, 0, 0, 0, 4'b0111, 4'b1000, 1, 5, 3));
    apply(mk("rst_mid",   1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    apply(mk("post_rst",  0, 0, 0, 0, 1, 0, -1,      4'b0000, 0, 0, 0));
    apply(mk("post_rst2", 0, 0, 0, 0, 1, 0, 4'b1111, 4'b1000, 0, 0, 0));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
